// File: rtl/gsim_sweep_ctrl.sv
// Sequencer for the GSIM 16-unknown Gauss-Seidel solver.
// Counts in the b samples, clears the x register file, runs N_ITER in-place
// sweeps (one datapath row request per unknown) and streams x[0..N_ROW-1].
// Drives addresses and strobes only; no arithmetic lives here.
module gsim_sweep_ctrl #(
    parameter int N_ROW  = 16,
    parameter int IDX_W  = 4,
    parameter int ITER_W = 8,
    parameter int N_ITER = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    output logic              b_we,
    output logic [IDX_W-1:0]  b_addr,
    output logic              x_we,
    output logic              x_clr,
    output logic [IDX_W-1:0]  x_addr,
    output logic              dp_start,
    output logic [IDX_W-1:0]  dp_row,
    input  logic              dp_done,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_addr,
    output logic              busy,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_e;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ROW - 1);
    localparam logic [ITER_W-1:0] ITER_END = ITER_W'(N_ITER);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;       // clear address, row, or output address
    logic [ITER_W-1:0] iter_q, iter_d;

    logic              clr_we_q, clr_we_d;
    logic              x_clr_q, x_clr_d;
    logic [IDX_W-1:0]  x_addr_q, x_addr_d;
    logic              dp_start_q, dp_start_d;
    logic [IDX_W-1:0]  dp_row_q, dp_row_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_addr_q, out_addr_d;
    logic              busy_q, busy_d;

    logic              load_fire;
    logic              row_done;

    assign load_fire = in_en && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign row_done  = (state_q == S_WAIT) && dp_done;

    // Next-state logic: load counting, clear walk, row/sweep stepping, output walk.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        idx_d    = idx_q;
        iter_d   = iter_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_en) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    state_d  = S_LOAD;
                    if (state_q == S_IDLE) begin
                        iter_d = '0;               // previous result held until now
                    end
                    if (ld_cnt_q == LAST_IDX) begin
                        ld_cnt_d = '0;
                        idx_d    = '0;
                        state_d  = S_CLR;
                    end
                end
            end
            S_CLR: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    iter_d  = '0;
                    state_d = S_ISSUE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        iter_d  = iter_q + 1'b1;
                        state_d = (iter_d == ITER_END) ? S_OUT : S_ISSUE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_OUT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every strobe leaves a flop.
    always_comb begin
        clr_we_d    = (state_d == S_CLR);
        x_clr_d     = (state_d == S_CLR);
        x_addr_d    = (state_d inside {S_CLR, S_ISSUE, S_WAIT}) ? idx_d : '0;
        dp_start_d  = (state_d == S_ISSUE);
        dp_row_d    = (state_d inside {S_ISSUE, S_WAIT}) ? idx_d : '0;
        out_valid_d = (state_d == S_OUT);
        out_addr_d  = (state_d == S_OUT) ? idx_d : '0;
        busy_d      = (state_d != S_IDLE);
    end

    // State, counters and registered outputs; reset aborts any solve in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ld_cnt_q    <= '0;
            idx_q       <= '0;
            iter_q      <= '0;
            clr_we_q    <= 1'b0;
            x_clr_q     <= 1'b0;
            x_addr_q    <= '0;
            dp_start_q  <= 1'b0;
            dp_row_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            idx_q       <= idx_d;
            iter_q      <= iter_d;
            clr_we_q    <= clr_we_d;
            x_clr_q     <= x_clr_d;
            x_addr_q    <= x_addr_d;
            dp_start_q  <= dp_start_d;
            dp_row_q    <= dp_row_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
        end
    end

    // b store strobes follow in_en directly so samples land in the cycle they arrive.
    assign b_we      = load_fire;
    assign b_addr    = ld_cnt_q;
    // The row result is only valid while dp_done is high, so the update write
    // is taken in that same cycle; clear writes come from a flop.
    assign x_we      = clr_we_q | row_done;
    assign x_clr     = x_clr_q;
    assign x_addr    = x_addr_q;
    assign dp_start  = dp_start_q;
    assign dp_row    = dp_row_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// Bench for gsim_sweep_ctrl: table-driven load vectors, hand-written reset and
// handshake sequences, and randomized solves checked against an event model.
module tb_gsim_sweep_ctrl;

    localparam int N_ROW  = 16;
    localparam int IDX_W  = 4;
    localparam int ITER_W = 8;
    localparam int N_ITER = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_en;
    logic              b_we;
    logic [IDX_W-1:0]  b_addr;
    logic              x_we;
    logic              x_clr;
    logic [IDX_W-1:0]  x_addr;
    logic              dp_start;
    logic [IDX_W-1:0]  dp_row;
    logic              dp_done;
    logic              out_valid;
    logic [IDX_W-1:0]  out_addr;
    logic              busy;
    logic [ITER_W-1:0] iter_cnt;

    gsim_sweep_ctrl #(
        .N_ROW (N_ROW),
        .IDX_W (IDX_W),
        .ITER_W(ITER_W),
        .N_ITER(N_ITER)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_en    (in_en),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .x_we     (x_we),
        .x_clr    (x_clr),
        .x_addr   (x_addr),
        .dp_start (dp_start),
        .dp_row   (dp_row),
        .dp_done  (dp_done),
        .out_valid(out_valid),
        .out_addr (out_addr),
        .busy     (busy),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int clr;
        int addr;
        int row;
        int cyc;
    } ev_t;

    typedef struct {
        bit in_en;
        bit exp_b_we;
        int exp_b_addr;
        bit exp_busy;
    } vec_t;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    int  k_fixed  = 3;     // >0: fixed datapath latency, 0: random 1..4
    int  hold_mode = 0;    // 0: one-cycle dp_done, 1: also in next cycle, 2: random
    int  k_pick;
    bit  done_sched[int];
    ev_t bq[$];
    ev_t xq[$];
    ev_t sq[$];
    ev_t oq[$];
    int  kq[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_b_we"},      b_we,      0);
        check({tag, "_b_addr"},    b_addr,    0);
        check({tag, "_x_we"},      x_we,      0);
        check({tag, "_x_clr"},     x_clr,     0);
        check({tag, "_x_addr"},    x_addr,    0);
        check({tag, "_dp_start"},  dp_start,  0);
        check({tag, "_dp_row"},    dp_row,    0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_addr"},  out_addr,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_iter_cnt"},  iter_cnt,  0);
    endtask

    task automatic clear_logs();
        bq.delete();
        xq.delete();
        sq.delete();
        oq.delete();
        kq.delete();
    endtask

    // Drive samples first..N_ROW-1, each optionally preceded by a random gap.
    task automatic load_b(input int first, input int max_gap);
        for (int i = first; i < N_ROW; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                @(posedge clk); #1; in_en = 1'b0;
            end
            @(posedge clk); #1; in_en = 1'b1;
        end
        @(posedge clk); #1; in_en = 1'b0;
    endtask

    // Run until the output burst has finished and busy drops; optional in_en noise.
    task automatic run_to_idle(input bit noise);
        int  n;
        bit  seen_out;
        bit  done;
        n = 0;
        seen_out = 1'b0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            in_en = (noise && !seen_out) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n++;
            if (out_valid) seen_out = 1'b1;
            if (seen_out && !busy) done = 1'b1;
        end
        check("idle_reached", done, 1);
    endtask

    // Event model of one solve: loads, clears, n_iter sweeps of row requests
    // each answered k cycles later, then the output burst.
    task automatic check_solve(input int n_iter, input int lat_exp);
        int total;
        int prev_end;
        total = n_iter * N_ROW;
        check("b_count",     bq.size(), N_ROW);
        check("x_count",     xq.size(), N_ROW + total);
        check("start_count", sq.size(), total);
        check("k_count",     kq.size(), total);
        check("out_count",   oq.size(), N_ROW);
        if (bq.size() == N_ROW && xq.size() == N_ROW + total && sq.size() == total &&
            kq.size() == total && oq.size() == N_ROW) begin
            for (int i = 0; i < N_ROW; i++) begin
                check("b_addr",   bq[i].addr, i);
                check("clr_flag", xq[i].clr,  1);
                check("clr_addr", xq[i].addr, i);
                check("clr_cyc",  xq[i].cyc,  bq[N_ROW-1].cyc + 1 + i);
            end
            prev_end = xq[N_ROW-1].cyc;
            for (int j = 0; j < total; j++) begin
                check("start_row", sq[j].row,          j % N_ROW);
                check("start_cyc", sq[j].cyc,          prev_end + 1);
                check("upd_flag",  xq[N_ROW+j].clr,    0);
                check("upd_addr",  xq[N_ROW+j].addr,   j % N_ROW);
                check("upd_row",   xq[N_ROW+j].row,    j % N_ROW);
                check("upd_cyc",   xq[N_ROW+j].cyc,    sq[j].cyc + kq[j]);
                prev_end = xq[N_ROW+j].cyc;
            end
            for (int i = 0; i < N_ROW; i++) begin
                check("out_addr", oq[i].addr, i);
                check("out_cyc",  oq[i].cyc,  prev_end + 1 + i);
            end
            if (lat_exp >= 0) check("latency", oq[0].cyc - bq[0].cyc, lat_exp);
        end
        check("iter_final", iter_cnt, n_iter);
        check("busy_idle",  busy, 0);
    endtask

    // Cycle counter and dp_done driver from the response schedule.
    initial begin
        dp_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            dp_done = done_sched.exists(cyc) ? 1'b1 : 1'b0;
        end
    end

    // Monitor: log strobes and schedule a datapath answer for each dp_start.
    always @(negedge clk) begin
        if (!reset) begin
            if (b_we)      bq.push_back('{0, int'(b_addr), 0, cyc});
            if (x_we)      xq.push_back('{int'(x_clr), int'(x_addr), int'(dp_row), cyc});
            if (out_valid) oq.push_back('{0, int'(out_addr), 0, cyc});
            if (dp_start) begin
                sq.push_back('{0, 0, int'(dp_row), cyc});
                k_pick = (k_fixed > 0) ? k_fixed : int'($urandom_range(1, 4));
                kq.push_back(k_pick);
                done_sched[cyc + k_pick] = 1'b1;
                if (hold_mode == 1 || (hold_mode == 2 && $urandom_range(0, 1) == 1))
                    done_sched[cyc + k_pick + 1] = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        reset = 1'b1;
        in_en = 1'b0;

        // Load vectors: gaps of 3 idle cycles after samples 4 and 9.
        cnt = 0;
        for (int s = 1; s <= N_ROW; s++) begin
            vecs.push_back('{1'b1, 1'b1, s - 1, s > 1});
            if (s == 4 || s == 9) begin
                repeat (3) vecs.push_back('{1'b0, 1'b0, s, 1'b1});
            end
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;

        // Load from the table with stray dp_done pulses that must be ignored.
        clear_logs();
        k_fixed = 3;
        hold_mode = 0;
        for (int c = cyc + 2; c < cyc + 12; c++) done_sched[c] = 1'b1;
        foreach (vecs[i]) begin
            @(posedge clk); #1; in_en = vecs[i].in_en;
            @(negedge clk);
            check("vec_b_we",   b_we,   vecs[i].exp_b_we);
            check("vec_b_addr", b_addr, vecs[i].exp_b_addr);
            check("vec_busy",   busy,   vecs[i].exp_busy);
            cnt += int'(vecs[i].in_en);
        end
        check("vec_samples", cnt, N_ROW);
        run_to_idle(1'b0);
        check_solve(N_ITER, -1);

        // dp_done also high in each ISSUE cycle; iter_cnt holds until load starts.
        clear_logs();
        k_fixed = 2;
        hold_mode = 1;
        repeat (3) @(negedge clk);
        check("iter_held_idle", iter_cnt, N_ITER);
        @(posedge clk); #1; in_en = 1'b1;
        @(negedge clk);
        check("iter_held_first_in", iter_cnt, N_ITER);
        @(posedge clk); #1; in_en = 1'b1;
        @(negedge clk);
        check("iter_cleared_load", iter_cnt, 0);
        load_b(2, 0);
        run_to_idle(1'b0);
        check_solve(N_ITER, 2 * N_ROW + N_ITER * N_ROW * (1 + 2));

        // Asynchronous reset mid-cycle while waiting on the datapath.
        clear_logs();
        k_fixed = 3;
        hold_mode = 0;
        load_b(0, 0);
        n = 0;
        while (sq.size() < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t1_reached_wait", sq.size() >= 5, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("t1");
        done_sched.delete();
        repeat (2) @(negedge clk);
        clear_logs();
        reset = 1'b0;

        // Randomized solves: random gaps, latencies, held dp_done and in_en noise.
        for (int r = 0; r < 4; r++) begin
            clear_logs();
            k_fixed = 0;
            hold_mode = 2;
            load_b(0, 3);
            run_to_idle(1'b1);
            check_solve(N_ITER, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
